// File: rtl/audio_fifo_sequencer.sv
// Audio sample pacer: takes one upstream sample per programmed period and
// writes it into the audio FIFO. Withholds writes when the FIFO is full or
// above the high-water mark, and keeps saturating drop/miss statistics.
module audio_fifo_sequencer #(
  parameter int DATA_W     = 32,
  parameter int USED_W     = 12,
  parameter int HIGH_WATER = 3584,
  parameter int CNT_W      = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       div_freq,
  input  logic              stop,
  input  logic              pause,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              fifo_full,
  input  logic [USED_W-1:0] fifo_used,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  // One extra bit so the high-water constant always fits the comparison.
  localparam logic [USED_W:0] HIGH_WATER_L = (USED_W+1)'(HIGH_WATER);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t              state_q, state_d;
  logic [31:0]         tick_cnt_q, tick_cnt_d;
  logic                pending_q, pending_d;
  logic                wrreq_q, wrreq_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [CNT_W-1:0]    miss_q, miss_d;

  logic                running;
  logic                handshake;
  logic                tick;
  logic                write_ok;

  // Ready depends only on registered pending/state, never on sample_valid.
  assign running      = (state_q == ST_RUN);
  assign sample_ready = pending_q & running;
  assign handshake    = sample_ready & sample_valid;
  // div_freq of 0 or 1 means a tick every cycle; otherwise tick once the
  // count reaches the period (or overshoots it after div_freq is lowered).
  assign tick         = running & ((div_freq <= 32'd1) | (tick_cnt_q >= (div_freq - 32'd1)));
  assign write_ok     = ~fifo_full & ({1'b0, fifo_used} < HIGH_WATER_L);

  // Next-state, pacing, write-path and statistics logic.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    pending_d  = pending_q;
    wrreq_d    = 1'b0;
    data_d     = data_q;
    drop_d     = drop_q;
    miss_d     = miss_q;

    if (stop)       state_d = ST_IDLE;
    else if (pause) state_d = ST_PAUSED;
    else            state_d = ST_RUN;

    // Entering (or staying in) IDLE clears pacing; PAUSED freezes it.
    if (state_d == ST_IDLE) begin
      tick_cnt_d = 32'd0;
      pending_d  = 1'b0;
    end else if (running) begin
      tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
      if (tick)           pending_d = 1'b1;
      else if (handshake) pending_d = 1'b0;
    end

    // A handshake in the cycle stop rises still completes its write.
    if (handshake) begin
      if (write_ok) begin
        wrreq_d = 1'b1;
        data_d  = sample_data;
      end else if (drop_q != CNT_MAX) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end

    // Only one tick may be outstanding; a further unserved tick is lost.
    if (tick && pending_q && !handshake && (miss_q != CNT_MAX))
      miss_d = miss_q + CNT_W'(1);
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= 32'd0;
      pending_q  <= 1'b0;
      wrreq_q    <= 1'b0;
      data_q     <= '0;
      drop_q     <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      wrreq_q    <= wrreq_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
      miss_q     <= miss_d;
    end
  end

  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = data_q;
  assign drop_count = drop_q;
  assign miss_count = miss_q;
  assign state      = state_q;

endmodule

// File: tb/tb_audio_fifo_sequencer.sv
// Bench for audio_fifo_sequencer: cycle model + write scoreboard, hand
// sequences for the multi-cycle corner cases, then a table of phases.
module tb_audio_fifo_sequencer;

  localparam int DATA_W = 32;
  localparam int USED_W = 12;
  localparam int HW     = 3584;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       div_freq = 32'd4;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              fifo_full = 1'b0;
  logic [USED_W-1:0] fifo_used = '0;
  logic              fifo_wrreq;
  logic [DATA_W-1:0] fifo_data;
  logic [CNT_W-1:0]  drop_count;
  logic [CNT_W-1:0]  miss_count;
  logic [1:0]        state;

  audio_fifo_sequencer #(
    .DATA_W(DATA_W), .USED_W(USED_W), .HIGH_WATER(HW), .CNT_W(CNT_W)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .div_freq(div_freq), .stop(stop),
    .pause(pause), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fifo_full(fifo_full), .fifo_used(fifo_used),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .drop_count(drop_count),
    .miss_count(miss_count), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int first_wr = 0;
  int step_no = 0;

  // Reference model registers
  logic [1:0]       m_state;
  logic [31:0]      m_cnt;
  logic             m_pend;
  logic             m_wr;
  logic [CNT_W-1:0] m_drop;
  logic [CNT_W-1:0] m_miss;
  logic [DATA_W-1:0] sb_q[$];

  typedef struct {
    logic       stop;
    logic       pause;
    logic [31:0] div;
    logic       valid;
    logic [USED_W-1:0] used;
    logic       full;
    int         ncyc;
    logic [1:0] exp_state;
  } phase_t;

  phase_t phases[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, step_no, act, exp);
    end
  endtask

  task automatic model_clear();
    m_state = 2'b00; m_cnt = 0; m_pend = 0; m_wr = 0; m_drop = 0; m_miss = 0;
    sb_q.delete();
  endtask

  // One clock: predict from pre-edge inputs, clock, then compare.
  task automatic step();
    logic [1:0] ns;
    logic rdy, hs, tk, ok;
    logic [31:0] ncnt;
    logic npend;
    logic [DATA_W-1:0] exp_d;
    rdy = m_pend && (m_state == 2'b01);
    hs  = rdy && sample_valid;
    tk  = (m_state == 2'b01) && ((div_freq <= 1) || (m_cnt >= div_freq - 1));
    ok  = !fifo_full && (int'(fifo_used) < HW);
    ns  = stop ? 2'b00 : (pause ? 2'b10 : 2'b01);
    ncnt = m_cnt; npend = m_pend;
    if (ns == 2'b00) begin
      ncnt = 0; npend = 0;
    end else if (m_state == 2'b01) begin
      ncnt = tk ? 0 : m_cnt + 1;
      if (tk) npend = 1; else if (hs) npend = 0;
    end
    if (hs && ok) sb_q.push_back(sample_data);
    if (hs && !ok && m_drop != '1) m_drop = m_drop + 1'b1;
    if (tk && m_pend && !hs && m_miss != '1) m_miss = m_miss + 1'b1;
    m_wr = hs && ok;
    m_state = ns; m_cnt = ncnt; m_pend = npend;

    @(posedge clk); #1;
    step_no++;
    chk("state", 32'(state), 32'(m_state));
    chk("ready", 32'(sample_ready), 32'(m_pend && m_state == 2'b01));
    chk("wrreq", 32'(fifo_wrreq), 32'(m_wr));
    chk("drop", 32'(drop_count), 32'(m_drop));
    chk("miss", 32'(miss_count), 32'(m_miss));
    if (fifo_wrreq || m_wr) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        exp_d = sb_q.pop_front();
        if (fifo_wrreq && m_wr) chk("data", fifo_data, exp_d);
      end
    end
    if (fifo_wrreq) begin
      wr_seen++;
      if (first_wr == 0) first_wr = step_no;
    end
    $display("step %0d st=%0d rdy=%0b wr=%0b data=%08h drop=%0d miss=%0d",
             step_no, state, sample_ready, fifo_wrreq, fifo_data, drop_count, miss_count);
    sample_data = $urandom;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold reset for a cycle, check cleared outputs, release away from the edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd0);
    chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_no = 0; wr_seen = 0; first_wr = 0;
  endtask

  task automatic set_in(input logic s, input logic p, input logic [31:0] d,
                        input logic v, input logic [USED_W-1:0] u, input logic f);
    stop = s; pause = p; div_freq = d; sample_valid = v; fifo_used = u; fifo_full = f;
  endtask

  initial begin
    phases[0] = '{1'b0, 1'b0, 32'd3, 1'b1, 12'd10,   1'b0, 20, 2'b01};
    phases[1] = '{1'b0, 1'b1, 32'd3, 1'b1, 12'd10,   1'b0, 6,  2'b10};
    phases[2] = '{1'b0, 1'b0, 32'd1, 1'b1, 12'd3583, 1'b0, 10, 2'b01};
    phases[3] = '{1'b0, 1'b0, 32'd2, 1'b1, 12'd3600, 1'b0, 10, 2'b01};
    phases[4] = '{1'b0, 1'b0, 32'd2, 1'b0, 12'd0,    1'b0, 12, 2'b01};
    phases[5] = '{1'b1, 1'b0, 32'd2, 1'b1, 12'd0,    1'b0, 4,  2'b00};
    phases[6] = '{1'b1, 1'b1, 32'd5, 1'b1, 12'd0,    1'b0, 3,  2'b00};
    phases[7] = '{1'b0, 1'b1, 32'd5, 1'b1, 12'd0,    1'b0, 3,  2'b10};
    phases[8] = '{1'b0, 1'b0, 32'd6, 1'b1, 12'd0,    1'b1, 20, 2'b01};
    phases[9] = '{1'b0, 1'b0, 32'd0, 1'b1, 12'd0,    1'b0, 8,  2'b01};

    model_clear();
    sample_data = $urandom;

    // 1: div=4, constant valid: RUN after first edge, first write at step 6,
    // then one write every 4 cycles.
    set_in(0, 0, 32'd4, 1, 12'd0, 0);
    do_reset();
    step();
    chk("t1_state_run", 32'(state), 32'd1);
    steps(43);
    chk("t1_first_wr", first_wr, 6);
    chk("t1_writes", wr_seen, 10);

    // 2: div=0, ready from step 2 and writes every cycle from step 3.
    set_in(0, 0, 32'd0, 1, 12'd0, 0);
    do_reset();
    steps(2);
    chk("t2_ready", 32'(sample_ready), 32'd1);
    steps(10);
    chk("t2_writes", wr_seen, 10);
    chk("t2_drop", 32'(drop_count), 32'd0);
    chk("t2_miss", 32'(miss_count), 32'd0);

    // 3: div=8 at the high-water mark: three drops, then writes resume.
    set_in(0, 0, 32'd8, 1, 12'd3584, 0);
    do_reset();
    steps(28);
    chk("t3_drop", 32'(drop_count), 32'd3);
    chk("t3_nowr", wr_seen, 0);
    fifo_used = 12'd100;
    steps(8);
    chk("t3_resume_wr", wr_seen, 1);
    chk("t3_drop_hold", 32'(drop_count), 32'd3);

    // 4: div=2, valid low for 11 cycles: four lost ticks, one write on valid.
    set_in(0, 0, 32'd2, 0, 12'd0, 0);
    do_reset();
    steps(11);
    sample_valid = 1'b1;
    step();
    chk("t4_one_wr", wr_seen, 1);
    steps(8);
    chk("t4_miss", 32'(miss_count), 32'd4);

    // 5: pause with counter at 2 of 5, release, then stop on a handshake.
    set_in(0, 0, 32'd5, 1, 12'd0, 0);
    do_reset();
    steps(2);
    pause = 1'b1;
    steps(20);
    chk("t5_paused", 32'(state), 32'd2);
    chk("t5_p_wr", wr_seen, 0);
    pause = 1'b0;
    steps(3);
    chk("t5_no_rdy_yet", 32'(sample_ready), 32'd0);
    step();
    chk("t5_rdy", 32'(sample_ready), 32'd1);
    stop = 1'b1;
    step();
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_inflight_wr", 32'(fifo_wrreq), 32'd1);
    step();
    chk("t5_idle_nowr", 32'(fifo_wrreq), 32'd0);
    chk("t5_idle_rdy", 32'(sample_ready), 32'd0);

    // 6: saturation of drop_count at 15, then asynchronous reset mid-run.
    set_in(0, 0, 32'd1, 1, 12'd0, 1);
    do_reset();
    steps(25);
    chk("t6_drop_sat", 32'(drop_count), 32'd15);
    fifo_full = 1'b0;
    steps(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_ar_drop", 32'(drop_count), 32'd0);
    chk("t6_ar_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("t6_ar_state", 32'(state), 32'd0);
    chk("t6_ar_ready", 32'(sample_ready), 32'd0);
    chk("t6_ar_data", fifo_data, 32'd0);

    // Table of mixed phases, continuous from a fresh reset.
    set_in(0, 0, 32'd3, 1, 12'd0, 0);
    do_reset();
    for (int p = 0; p < 10; p++) begin
      set_in(phases[p].stop, phases[p].pause, phases[p].div,
             phases[p].valid, phases[p].used, phases[p].full);
      steps(phases[p].ncyc);
      chk("tbl_state", 32'(state), 32'(phases[p].exp_state));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
